hp_manager: RTL



---
 rtl/hp_pkg.sv | 18 +
 rtl/hp_manager_wl_event_det.sv | 21 ++
 rtl/hp_manager.sv | 91 +++++++++
 3 files changed

// File: rtl/hp_pkg.sv
// hp_pkg: round-result codes, match states and result codes shared by the HP manager.
package hp_pkg;
    localparam logic [2:0] WL_NONE  = 3'b000;
    localparam logic [2:0] WL_MINE  = 3'b001;
    localparam logic [2:0] WL_ENEMY = 3'b010;
    localparam logic [2:0] WL_DRAW  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_MINE  = 2'b01;
    localparam logic [1:0] RES_ENEMY = 2'b10;
    localparam logic [1:0] RES_DRAW  = 2'b11;
endpackage

// File: rtl/hp_manager_wl_event_det.sv
// wl_event_det: validates the round-result code and strobes once per 000 -> nonzero edge.
module wl_event_det
    import hp_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] wl,
    output logic       ev,
    output logic [2:0] code
);
    logic [2:0] prev;

    always_comb begin
        code = (wl == WL_MINE || wl == WL_ENEMY || wl == WL_DRAW) ? wl : WL_NONE;
        ev   = code != WL_NONE && prev == WL_NONE;
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST) prev <= WL_NONE;
        else      prev <= code;
endmodule

// File: rtl/hp_manager.sv
// hp_manager: HP counters and idle/play/over match FSM driven by round results.
// Optional HP_COOLDOWN_EN adds a post-hit lockout of CD_CYC cycles.
module hp_manager
    import hp_pkg::*;
#(
    parameter int HP_W    = 4,
    parameter int HP_INIT = 5,
    parameter int DMG     = 1,
    parameter int CD_CYC  = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      WL_IN,
    input  logic            START,
    output logic [HP_W-1:0] MY_HP,
    output logic [HP_W-1:0] EN_HP,
    output logic [1:0]      STATE,
    output logic [1:0]      RESULT,
    output logic            HIT
);
    localparam logic [HP_W-1:0] INIT_V = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] DMG_V  = HP_W'(DMG);

    if (HP_INIT > 2**HP_W - 1 || DMG < 1 || CD_CYC < 0)
        $error("hp_manager: illegal parameter combination");

    state_t          st;
    logic            ev, cd_ok, acc, my_dmg, en_dmg;
    logic [2:0]      code;
    logic [HP_W-1:0] my_nx, en_nx;

    wl_event_det u_det (
        .CLK (CLK),
        .RST (RST),
        .wl  (WL_IN),
        .ev  (ev),
        .code(code)
    );

    always_comb begin
        my_dmg = code == WL_ENEMY || code == WL_DRAW;
        en_dmg = code == WL_MINE  || code == WL_DRAW;
        my_nx  = !my_dmg ? MY_HP : int'(MY_HP) <= DMG ? '0 : MY_HP - DMG_V;
        en_nx  = !en_dmg ? EN_HP : int'(EN_HP) <= DMG ? '0 : EN_HP - DMG_V;
        acc    = st == ST_PLAY && ev && cd_ok;
    end

`ifdef HP_COOLDOWN_EN
    localparam int CD_W = CD_CYC < 1 ? 1 : $clog2(CD_CYC + 1);
    logic [CD_W-1:0] cd;

    always_ff @(posedge CLK or negedge RST)
        if (!RST)                     cd <= '0;
        else if (st == ST_OVER && START) cd <= '0;
        else if (acc)                 cd <= CD_W'(CD_CYC);
        else if (cd != '0)            cd <= cd - CD_W'(1);

    assign cd_ok = cd == '0;
`else
    assign cd_ok = 1'b1;
`endif

    assign STATE = st;

    // the damaging update itself decides the transition to OVER and the winner
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            st     <= ST_IDLE;
            MY_HP  <= INIT_V;
            EN_HP  <= INIT_V;
            RESULT <= RES_NONE;
            HIT    <= 1'b0;
        end else begin
            HIT <= acc;
            if (acc) begin
                MY_HP <= my_nx;
                EN_HP <= en_nx;
                if (my_nx == '0 || en_nx == '0) begin
                    st     <= ST_OVER;
                    RESULT <= {my_nx == '0, en_nx == '0};
                end
            end else if (st == ST_IDLE && START) begin
                st <= ST_PLAY;
            end else if (st == ST_OVER && START) begin
                st     <= ST_PLAY;
                MY_HP  <= INIT_V;
                EN_HP  <= INIT_V;
                RESULT <= RES_NONE;
            end
        end
endmodule
